// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer definitions: default address width, pointer type,
// and binary/Gray conversion helpers used by both the write and read sides.
package fifo_pkg;

  localparam int unsigned ADDR_SIZE  = 4;
  localparam int unsigned GRAY_MAX_W = 32;

  typedef logic [ADDR_SIZE:0] ptr_t;

  // Helpers work on zero-extended values; callers truncate the result to their
  // own pointer width, so any width up to GRAY_MAX_W is handled.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int unsigned i = 1; i < GRAY_MAX_W; i++) begin
      b[GRAY_MAX_W-1-i] = b[GRAY_MAX_W-i] ^ g[GRAY_MAX_W-1-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop clock-domain-crossing synchroniser, parameterised width,
// asynchronous active-low reset. Shared by the write and read sides.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/full_checker.sv
// Write-side pointer and registered, pessimistic full flag for the async FIFO.
// Optional almost-full/occupancy outputs are enabled by FULL_CHECKER_ALMOST_FULL_EN.
module full_checker #(
  parameter int unsigned ADDR_SIZE = fifo_pkg::ADDR_SIZE
`ifdef FULL_CHECKER_ALMOST_FULL_EN
  , parameter int unsigned AF_THRESH = (1 << ADDR_SIZE) - 2
`endif
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_en,
  input  logic [ADDR_SIZE:0]   r_ptr_gray,
  output logic                 w_full,
  output logic [ADDR_SIZE:0]   w_ptr_gray,
  output logic [ADDR_SIZE-1:0] w_addr,
  output logic                 w_ovf
`ifdef FULL_CHECKER_ALMOST_FULL_EN
  , output logic               w_almost_full
  , output logic [ADDR_SIZE:0] w_level
`endif
);

  import fifo_pkg::*;

  localparam int unsigned PW = ADDR_SIZE + 1;

  logic [ADDR_SIZE:0] rq2;
  logic               w_inc;
  logic [ADDR_SIZE:0] w_ptr_bin_q, w_ptr_bin_d;
  logic [ADDR_SIZE:0] w_ptr_gray_q, w_ptr_gray_d;
  logic [ADDR_SIZE:0] full_cmp;
  logic               w_full_q, w_full_d;
  logic               w_ovf_q, w_ovf_d;

  sync_2ff #(
    .WIDTH(PW)
  ) u_rptr_sync (
    .clk  (w_clk),
    .rst_n(w_rst),
    .d    (r_ptr_gray),
    .q    (rq2)
  );

  // Full when the next write pointer equals the read pointer with the two
  // top Gray bits inverted, i.e. exactly one full lap ahead.
  always_comb begin
    w_inc        = w_en & ~w_full_q;
    w_ptr_bin_d  = w_ptr_bin_q + {{ADDR_SIZE{1'b0}}, w_inc};
    w_ptr_gray_d = PW'(bin2gray(GRAY_MAX_W'(w_ptr_bin_d)));
    full_cmp     = {~rq2[ADDR_SIZE -: 2], rq2[ADDR_SIZE-2:0]};
    w_full_d     = (w_ptr_gray_d == full_cmp);
    w_ovf_d      = w_ovf_q | (w_en & w_full_q);
  end

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      w_ptr_bin_q  <= '0;
      w_ptr_gray_q <= '0;
      w_full_q     <= 1'b0;
      w_ovf_q      <= 1'b0;
    end else begin
      w_ptr_bin_q  <= w_ptr_bin_d;
      w_ptr_gray_q <= w_ptr_gray_d;
      w_full_q     <= w_full_d;
      w_ovf_q      <= w_ovf_d;
    end
  end

  assign w_full     = w_full_q;
  assign w_ptr_gray = w_ptr_gray_q;
  assign w_addr     = w_ptr_bin_q[ADDR_SIZE-1:0];
  assign w_ovf      = w_ovf_q;

`ifdef FULL_CHECKER_ALMOST_FULL_EN
  logic [ADDR_SIZE:0] rq2_bin;
  logic [ADDR_SIZE:0] w_level_q, w_level_d;
  logic               w_af_q, w_af_d;

  always_comb begin
    rq2_bin   = PW'(gray2bin(GRAY_MAX_W'(rq2)));
    w_level_d = w_ptr_bin_d - rq2_bin;
    w_af_d    = (GRAY_MAX_W'(w_level_d) >= AF_THRESH);
  end

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      w_level_q <= '0;
      w_af_q    <= 1'b0;
    end else begin
      w_level_q <= w_level_d;
      w_af_q    <= w_af_d;
    end
  end

  assign w_level       = w_level_q;
  assign w_almost_full = w_af_q;
`endif

endmodule

// File: tb/tb_full_checker.sv
// Scoreboard bench for full_checker (ADDR_SIZE=4): the driver queues expected
// post-edge outputs, a monitor compares them on the following falling edge.
module tb_full_checker;

  localparam int unsigned AW = 4;
  localparam int unsigned PW = AW + 1;

  logic          w_clk = 1'b0;
  logic          w_rst;
  logic          w_en;
  logic [PW-1:0] r_ptr_gray;
  logic          w_full;
  logic [PW-1:0] w_ptr_gray;
  logic [AW-1:0] w_addr;
  logic          w_ovf;
`ifdef FULL_CHECKER_ALMOST_FULL_EN
  logic          w_almost_full;
  logic [PW-1:0] w_level;
`endif

  full_checker #(
    .ADDR_SIZE(AW)
`ifdef FULL_CHECKER_ALMOST_FULL_EN
    , .AF_THRESH(14)
`endif
  ) dut (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .w_en         (w_en),
    .r_ptr_gray   (r_ptr_gray),
    .w_full       (w_full),
    .w_ptr_gray   (w_ptr_gray),
    .w_addr       (w_addr),
    .w_ovf        (w_ovf)
`ifdef FULL_CHECKER_ALMOST_FULL_EN
    , .w_almost_full(w_almost_full)
    , .w_level      (w_level)
`endif
  );

  typedef struct {
    int unsigned   cyc;
    string         name;
    logic [PW-1:0] gray;
    logic [AW-1:0] addr;
    logic          full;
    logic          ovf;
    logic          lvl_on;
    logic [PW-1:0] level;
    logic          af;
  } exp_t;

  exp_t          q[$];
  int unsigned   cyc    = 0;
  int unsigned   n_chk  = 0;
  int unsigned   n_fail = 0;
  logic          lvl_on = 1'b0;
  logic [PW-1:0] exp_lvl = '0;
  logic          exp_af  = 1'b0;

  always #5 w_clk = ~w_clk;
  always @(posedge w_clk) cyc++;

  function automatic logic [PW-1:0] g(input int unsigned b);
    logic [PW-1:0] t;
    t = PW'(b);
    return t ^ (t >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every queued expectation due at this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge w_clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        chk($sformatf("%s.cycle", e.name), cyc, e.cyc);
        chk($sformatf("%s.w_ptr_gray", e.name), 32'(w_ptr_gray), 32'(e.gray));
        chk($sformatf("%s.w_addr", e.name), 32'(w_addr), 32'(e.addr));
        chk($sformatf("%s.w_full", e.name), 32'(w_full), 32'(e.full));
        chk($sformatf("%s.w_ovf", e.name), 32'(w_ovf), 32'(e.ovf));
`ifdef FULL_CHECKER_ALMOST_FULL_EN
        if (e.lvl_on) begin
          chk($sformatf("%s.w_level", e.name), 32'(w_level), 32'(e.level));
          chk($sformatf("%s.w_almost_full", e.name), 32'(w_almost_full), 32'(e.af));
        end
`endif
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic en, input logic [PW-1:0] rp, input string nm,
                      input logic [PW-1:0] gray, input logic [AW-1:0] addr,
                      input logic full, input logic ovf);
    exp_t e;
    w_en       = en;
    r_ptr_gray = rp;
    e.cyc    = cyc + 1;
    e.name   = nm;
    e.gray   = gray;
    e.addr   = addr;
    e.full   = full;
    e.ovf    = ovf;
    e.lvl_on = lvl_on;
    e.level  = exp_lvl;
    e.af     = exp_af;
    q.push_back(e);
    @(posedge w_clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge w_clk);
    #1;
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic pulse_reset(input logic en, input string nm);
    wait_drain();
    w_en       = en;
    r_ptr_gray = '0;
    w_rst      = 1'b0;
    #1;
    chk($sformatf("%s.w_ptr_gray", nm), 32'(w_ptr_gray), 0);
    chk($sformatf("%s.w_addr", nm), 32'(w_addr), 0);
    chk($sformatf("%s.w_full", nm), 32'(w_full), 0);
    chk($sformatf("%s.w_ovf", nm), 32'(w_ovf), 0);
`ifdef FULL_CHECKER_ALMOST_FULL_EN
    chk($sformatf("%s.w_level", nm), 32'(w_level), 0);
    chk($sformatf("%s.w_almost_full", nm), 32'(w_almost_full), 0);
`endif
    #1;
    w_en  = 1'b0;
    w_rst = 1'b1;
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    w_rst      = 1'b0;
    w_en       = 1'b1;
    r_ptr_gray = '0;
    @(posedge w_clk);
    #1;

    // Reset held with writes requested: nothing may move.
    for (int i = 0; i < 3; i++) step(1'b1, 5'b00000, "reset", 5'b00000, 4'd0, 1'b0, 1'b0);
    w_en  = 1'b0;
    w_rst = 1'b1;
    step(1'b0, 5'b00000, "idle", 5'b00000, 4'd0, 1'b0, 1'b0);

    // Fill 16 entries against a stationary read pointer.
    lvl_on = 1'b1;
    for (int unsigned i = 1; i <= 16; i++) begin
      exp_lvl = PW'(i);
      exp_af  = (i >= 14);
      step(1'b1, 5'b00000, $sformatf("fill%0d", i),
           (i == 16) ? 5'b11000 : g(i), AW'(i), (i == 16), 1'b0);
    end
    lvl_on = 1'b0;

    // Overflow attempt while full; flag is sticky.
    step(1'b1, 5'b00000, "ovf", 5'b11000, 4'd0, 1'b1, 1'b1);
    step(1'b0, 5'b00000, "ovf_hold1", 5'b11000, 4'd0, 1'b1, 1'b1);
    step(1'b0, 5'b00000, "ovf_hold2", 5'b11000, 4'd0, 1'b1, 1'b1);

    // One read becomes visible after rq1, rq2, then the w_full register.
    step(1'b0, 5'b00001, "drain_e1", 5'b11000, 4'd0, 1'b1, 1'b1);
    step(1'b0, 5'b00001, "drain_e2", 5'b11000, 4'd0, 1'b1, 1'b1);
    step(1'b0, 5'b00001, "drain_e3", 5'b11000, 4'd0, 1'b0, 1'b1);
    step(1'b1, 5'b00001, "refill", 5'b11001, 4'd1, 1'b1, 1'b1);
    step(1'b0, 5'b00001, "refill_hold", 5'b11001, 4'd1, 1'b1, 1'b1);

    pulse_reset(1'b1, "async_rst1");

    // 32 writes with the read pointer two writes behind: full never asserts.
    for (int unsigned k = 0; k < 32; k++) begin
      step(1'b1, (k >= 2) ? g(k - 2) : 5'b00000, $sformatf("wrap%0d", k),
           (k == 31) ? 5'b00000 : g(k + 1), AW'(k + 1), 1'b0, 1'b0);
    end
    step(1'b0, g(30), "wrap_end", 5'b00000, 4'd0, 1'b0, 1'b0);

`ifdef FULL_CHECKER_ALMOST_FULL_EN
    pulse_reset(1'b0, "af_pre_rst");
    lvl_on = 1'b1;
    for (int unsigned i = 1; i <= 15; i++) begin
      exp_lvl = PW'(i);
      exp_af  = (i >= 14);
      step(1'b1, 5'b00000, $sformatf("af%0d", i), g(i), AW'(i), 1'b0, 1'b0);
    end
    lvl_on = 1'b0;
    pulse_reset(1'b1, "af_mid_rst");
`endif

    wait_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
